// File: rtl/seq_detector.sv
// Serial pattern detector with a runtime-loadable pattern and length,
// selectable overlapping/non-overlapping detection and a saturating match counter.
module seq_detector #(
    parameter int  MAX_LEN   = 8,
    parameter int  CNT_WIDTH = 8,
    localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 load,
    input  logic [MAX_LEN-1:0]   pattern_in,
    input  logic [LEN_W-1:0]     len_in,
    input  logic                 overlap,
    input  logic                 enable,
    input  logic                 serial_in,
    input  logic                 clr_count,
    output logic                 match,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic                 armed,
    output logic                 cfg_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        MATCH = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [MAX_LEN-1:0]   pattern, pattern_next;
    logic [LEN_W-1:0]     len, len_next;
    logic [MAX_LEN-1:0]   hist, hist_next;
    logic [LEN_W-1:0]     fill, fill_next;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 cfg_err_next;

    logic [MAX_LEN-1:0]   mask;
    logic [MAX_LEN-1:0]   shift_hist;
    logic [LEN_W-1:0]     shift_fill;
    logic                 len_ok;
    logic                 hit;
    logic                 enter_match;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path infers a latch.
        state_next   = state;
        pattern_next = pattern;
        len_next     = len;
        hist_next    = hist;
        fill_next    = fill;
        cfg_err_next = 1'b0;
        enter_match  = 1'b0;

        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        shift_hist = {hist[MAX_LEN-2:0], serial_in};
        shift_fill = (fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill + 1'b1;
        hit        = (shift_fill >= len) && ((shift_hist & mask) == (pattern & mask));
        len_ok     = (len_in != '0) && (len_in <= LEN_W'(MAX_LEN));

        if (load) begin
            if (len_ok) begin
                pattern_next = pattern_in;
                len_next     = len_in;
                hist_next    = '0;
                fill_next    = '0;
                state_next   = HUNT;
            end else begin
                cfg_err_next = 1'b1;
                // A match is only ever a one-cycle state; otherwise state is left alone.
                if (state == MATCH) state_next = HUNT;
            end
        end else if (state != IDLE) begin
            state_next = HUNT;
            if (enable) begin
                hist_next = shift_hist;
                fill_next = shift_fill;
                if (hit) begin
                    state_next  = MATCH;
                    enter_match = 1'b1;
                    if (!overlap) begin
                        hist_next = '0;
                        fill_next = '0;
                    end
                end
            end
        end

        count_next = match_count;
        if (clr_count) begin
            count_next = enter_match ? CNT_WIDTH'(1) : '0;
        end else if (enter_match && (match_count != '1)) begin
            count_next = match_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            pattern     <= '0;
            len         <= '0;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_next;
            pattern     <= pattern_next;
            len         <= len_next;
            hist        <= hist_next;
            fill        <= fill_next;
            match_count <= count_next;
            cfg_err     <= cfg_err_next;
        end
    end

    assign match = (state == MATCH);
    assign armed = (state != IDLE);

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: directed scenarios plus randomized traffic
// compared against a bit-queue reference model; a CNT_WIDTH=2 copy checks saturation.
module tb_seq_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               n_rst = 1'b0;
    logic               load = 1'b0;
    logic [MAX_LEN-1:0] pattern_in = '0;
    logic [LEN_W-1:0]   len_in = '0;
    logic               overlap = 1'b0;
    logic               enable = 1'b0;
    logic               serial_in = 1'b0;
    logic               clr_count = 1'b0;

    logic               match, armed, cfg_err;
    logic [7:0]         match_count;
    logic               match2, armed2, cfg_err2;
    logic [1:0]         count2;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          q[$];
    bit          m_armed;
    int          m_len;
    logic [7:0]  m_pat;
    logic        exp_match;
    logic        exp_cfg_err;
    int          exp_cnt8;
    int          exp_cnt2;

    seq_detector #(.MAX_LEN(MAX_LEN), .CNT_WIDTH(8)) dut (
        .clk(clk), .n_rst(n_rst), .load(load), .pattern_in(pattern_in), .len_in(len_in),
        .overlap(overlap), .enable(enable), .serial_in(serial_in), .clr_count(clr_count),
        .match(match), .match_count(match_count), .armed(armed), .cfg_err(cfg_err)
    );

    seq_detector #(.MAX_LEN(MAX_LEN), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .n_rst(n_rst), .load(load), .pattern_in(pattern_in), .len_in(len_in),
        .overlap(overlap), .enable(enable), .serial_in(serial_in), .clr_count(clr_count),
        .match(match2), .match_count(count2), .armed(armed2), .cfg_err(cfg_err2)
    );

    always #5 clk = ~clk;

    function automatic bit tail_matches();
        int n = q.size();
        if (n < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (q[n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_armed     = 1'b0;
        m_len       = 0;
        m_pat       = '0;
        exp_match   = 1'b0;
        exp_cfg_err = 1'b0;
        exp_cnt8    = 0;
        exp_cnt2    = 0;
    endtask

    task automatic model_edge(input logic ld, input logic [7:0] pi, input logic [3:0] li,
                              input logic ov, input logic en, input logic si, input logic cl);
        bit inc = 1'b0;
        exp_cfg_err = 1'b0;
        exp_match   = 1'b0;
        if (ld) begin
            if (li >= 1 && li <= MAX_LEN) begin
                m_pat   = pi;
                m_len   = int'(li);
                m_armed = 1'b1;
                q.delete();
            end else begin
                exp_cfg_err = 1'b1;
            end
        end else if (m_armed && en) begin
            q.push_back(si);
            if (q.size() > MAX_LEN) void'(q.pop_front());
            inc = tail_matches();
            if (inc && !ov) q.delete();
            exp_match = inc;
        end
        if (cl) begin
            exp_cnt8 = inc ? 1 : 0;
            exp_cnt2 = inc ? 1 : 0;
        end else if (inc) begin
            if (exp_cnt8 < 255) exp_cnt8++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
    endtask

    // Drives one cycle of inputs, advances the model at the edge, returns #1 after it.
    task automatic step(input logic ld, input logic [7:0] pi, input logic [3:0] li,
                        input logic ov, input logic en, input logic si, input logic cl);
        load = ld; pattern_in = pi; len_in = li; overlap = ov;
        enable = en; serial_in = si; clr_count = cl;
        @(posedge clk);
        model_edge(ld, pi, li, ov, en, si, cl);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        serial_in = 1'b1; enable = 1'b1; load = 1'b1; len_in = 4'd3;
        #12;
        checks++;
        if ({match, armed, cfg_err, match_count, count2} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got match=%b armed=%b cfg_err=%b cnt=%0d cnt2=%0d, want all 0",
                     match, armed, cfg_err, match_count, count2);
        end
        load = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_armed: got %b want 0", armed);
        end
    endtask

    task automatic test_cfg_err();
        logic [3:0] bad [2] = '{4'd0, 4'(MAX_LEN + 1)};
        logic [3:0] bits = 4'b1101;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'h0D, bad[i], 1'b1, 1'b1, 1'b1, 1'b0);
            checks++;
            if (cfg_err !== 1'b1 || armed !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_pulse[%0d]: got cfg_err=%b armed=%b want 1/0", i, cfg_err, armed);
            end
            step(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
            checks++;
            if (cfg_err !== 1'b0 || armed !== 1'b0 || match !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_drop[%0d]: got cfg_err=%b armed=%b match=%b want 0/0/0",
                         i, cfg_err, armed, match);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, bits[i], 1'b0);
            checks++;
            if (match !== 1'b0 || armed !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignores_serial: got match=%b armed=%b want 0/0", match, armed);
            end
        end
    endtask

    task automatic run_1101(input logic ov, input string name);
        logic [6:0] stream = 7'b1101101;
        logic [6:0] want   = ov ? 7'b0001001 : 7'b0001000;
        step(1'b1, 8'b0000_1101, 4'd4, ov, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 8'h00, 4'd0, ov, 1'b1, stream[6 - i], 1'b0);
            checks++;
            if (match !== want[6 - i] || match !== exp_match) begin
                errors++;
                $display("FAIL %s bit%0d: got match=%b want %b (model %b)",
                         name, i + 1, match, want[6 - i], exp_match);
            end
        end
        checks++;
        if (match_count !== (ov ? 8'd2 : 8'd1)) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", name, match_count, ov ? 2 : 1);
        end
    endtask

    task automatic test_overlap();
        run_1101(1'b1, "overlap");
    endtask

    task automatic test_non_overlap();
        run_1101(1'b0, "non_overlap");
    endtask

    task automatic test_enable_gaps();
        logic [3:0] bits = 4'b1101;
        step(1'b1, 8'b0000_1101, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, bits[i], 1'b0);
            checks++;
            if (match !== (i == 0) || match !== exp_match) begin
                errors++;
                $display("FAIL enable_gap_bit%0d: got match=%b want %b", 4 - i, match, i == 0);
            end
            step(1'b0, 8'h00, 4'd0, 1'b1, 1'b0, ~bits[i], 1'b0);
            checks++;
            if (match !== 1'b0) begin
                errors++;
                $display("FAIL enable_gap_idle%0d: got match=%b want 0", 4 - i, match);
            end
        end
        checks++;
        if (match_count !== 8'd1) begin
            errors++;
            $display("FAIL enable_gap_count: got %0d want 1", match_count);
        end
    endtask

    task automatic test_saturation();
        int want [5] = '{1, 2, 3, 3, 3};
        step(1'b1, 8'h01, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
            checks++;
            if (int'(count2) != want[i] || match !== 1'b1 || int'(count2) != exp_cnt2) begin
                errors++;
                $display("FAIL saturate[%0d]: got cnt2=%0d match=%b want %0d/1", i, count2, match, want[i]);
            end
        end
        step(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (count2 !== 2'd1 || match_count !== 8'd1) begin
            errors++;
            $display("FAIL clr_with_match: got cnt2=%0d cnt=%0d want 1/1", count2, match_count);
        end
        step(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (count2 !== 2'd0 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL clr_alone: got cnt2=%0d cnt=%0d want 0/0", count2, match_count);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [2:0] pre = 3'b110;
        step(1'b1, 8'b0000_1101, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i >= 0; i--) step(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, pre[i], 1'b0);
        n_rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({match, armed, cfg_err, match_count, count2} !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got match=%b armed=%b cfg_err=%b cnt=%0d, want all 0",
                     match, armed, cfg_err, match_count);
        end
        n_rst = 1'b1;
        step(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (match !== 1'b0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_match: got match=%b armed=%b want 0/0", match, armed);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic ld = (c == 0) || ($urandom_range(0, 19) == 0);
            logic [3:0] li = 4'($urandom_range(1, 4));
            if ($urandom_range(0, 9) == 0) li = 4'($urandom_range(5, MAX_LEN));
            step(ld, 8'($urandom), li, 1'($urandom), ($urandom_range(0, 3) != 0),
                 1'($urandom), ($urandom_range(0, 15) == 0));
            checks++;
            if (match !== exp_match || armed !== m_armed || cfg_err !== exp_cfg_err ||
                int'(match_count) != exp_cnt8 || int'(count2) != exp_cnt2) begin
                errors++;
                $display("FAIL random[%0d]: got match=%b armed=%b cfg_err=%b cnt=%0d cnt2=%0d want %b/%b/%b/%0d/%0d",
                         c, match, armed, cfg_err, match_count, count2,
                         exp_match, m_armed, exp_cfg_err, exp_cnt8, exp_cnt2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cfg_err();
        test_overlap();
        test_non_overlap();
        test_enable_gaps();
        test_saturation();
        test_reset_mid_stream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 8, maximum pattern length in bits, legal range 2..32.
REQ-002 SHALL provide parameter CNT_WIDTH, default 8, width of the match counter.
REQ-003 SHALL derive LEN_W = $clog2(MAX_LEN+1) as the width of the length fields.
REQ-004 clk  input  1  clock; all state changes occur on its rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 load  input  1  when high, latches pattern_in and len_in as the new configuration.
REQ-007 pattern_in  input  MAX_LEN  target pattern; bit len-1 is the first serial bit and bit 0 is the last serial bit.
REQ-008 len_in  input  LEN_W  pattern length in bits; the legal range is 1..MAX_LEN.
REQ-009 overlap  input  1  1 = overlapping detection; 0 = non-overlapping detection.
REQ-010 enable  input  1  serial_in is sampled only when enable is high.
REQ-011 serial_in  input  1  serial data bit.
REQ-012 clr_count  input  1  synchronous clear of match_count.
REQ-013 match  output  1  Moore output; high while state is MATCH.
REQ-014 match_count  output  CNT_WIDTH  saturating count of matches.
REQ-015 armed  output  1  high when a valid configuration is loaded (state is not IDLE).
REQ-016 cfg_err  output  1  registered one-cycle pulse on a rejected load.

Function
REQ-017 SHALL implement states IDLE, HUNT and MATCH; match = (state==MATCH) only, with no combinational path from any input to match.
REQ-018 In IDLE, serial_in SHALL be ignored; only an accepted load leaves IDLE.
REQ-019 An accepted load (1 <= len_in <= MAX_LEN) SHALL latch pattern and length, clear history and fill count, and go to HUNT, from any state.
REQ-020 A rejected load (len_in==0 or len_in>MAX_LEN) SHALL leave config, state, history and fill unchanged and pulse cfg_err for one cycle.
REQ-021 On a load cycle, load SHALL take priority and serial_in SHALL be discarded.
REQ-022 On each enabled, non-load edge outside IDLE, SHALL shift: hist <= {hist[MAX_LEN-2:0], serial_in}; fill <= min(fill+1, MAX_LEN).
REQ-023 A match occurs when the new fill >= len and the low len bits of the new hist equal the low len bits of the pattern.
REQ-024 On a match, the next state SHALL be MATCH; otherwise the next state SHALL be HUNT, including from MATCH.
REQ-025 Latency: match SHALL be high for the one cycle following the edge that sampled the final pattern bit.
REQ-026 Back-to-back matches SHALL keep match high on consecutive cycles; for example, pattern "1", len 1, stream 111 holds match high for 3 cycles.
REQ-027 overlap=1: history and fill SHALL be retained after a match.
REQ-028 overlap=0: fill and hist SHALL be cleared on the edge that enters MATCH, so no bit is reused.
REQ-029 enable=0: hist and fill SHALL hold; MATCH SHALL still return to HUNT after one cycle.
REQ-030 match_count SHALL increment on every edge that enters MATCH and SHALL saturate at 2^CNT_WIDTH-1 without wrapping.
REQ-031 When clr_count and an increment occur in the same cycle, match_count SHALL become 1; clr_count alone SHALL make it 0.
REQ-032 A load SHALL NOT clear match_count.

Reset
REQ-033 While n_rst is low, SHALL asynchronously force: state=IDLE, pattern=0, len=0, hist=0, fill=0, match=0, match_count=0, armed=0, cfg_err=0.
REQ-034 Reset asserted mid-stream SHALL discard all partial progress and the configuration; after reset release, a new load is required.

Verification
REQ-035 Load pattern 4'b1101, len 4, overlap=1; stream 1,1,0,1,1,0,1 -> match high after bits 4 and 7; match_count=2.
REQ-036 Same stream with overlap=0 -> match high after bit 4 only; match_count=1.
REQ-037 len_in=0, then len_in=MAX_LEN+1 -> cfg_err pulses twice, armed stays 0, serial input is ignored.
REQ-038 CNT_WIDTH=2, pattern "1", len 1, stream of 5 ones -> match_count reads 1,2,3,3,3; clr_count on a match cycle -> 1.
REQ-039 Pattern 1101 with enable low between every bit -> the single match occurs after the 4th enabled bit; history holds during gaps.
REQ-040 n_rst pulsed after bits 1,1,0 -> all outputs 0 and armed=0; the following bit 1 produces no match.
